// File: rtl/nclassic_pkg.sv
// rtl/nclassic_pkg.sv - Shared keycode width and key sequencer state encoding
package nclassic_pkg;

    localparam int KEYCODE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - Keycode FIFO with occupancy count; clear beats push and pop
module key_fifo
    import nclassic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   clear_in,
    input  logic                   push_in,
    input  logic [KEYCODE_W-1:0]   push_data_in,
    input  logic                   pop_in,
    output logic [KEYCODE_W-1:0]   head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [KEYCODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    // Full is judged on the registered count, so a same-cycle pop never frees room for a push
    assign full_o  = (count_o == (AW + 1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign push_ok = push_in && !full_o && !clear_in;
    assign pop_ok  = pop_in && !empty_o && !clear_in;
    assign head_o  = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (clear_in) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_o <= count_o + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_o <= count_o - 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_sequencer.sv
// rtl/key_sequencer.sv - Presents queued keycodes to the core as timed key-down strobes
module key_sequencer
    import nclassic_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int HOLD_CYCLES    = 4,
    parameter int GAP_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   push_in,
    input  logic [KEYCODE_W-1:0]   push_keycode_in,
    input  logic                   clear_in,
    input  logic                   core_ack_in,
    output logic                   key_pending_o,
    output logic [KEYCODE_W-1:0]   keycode_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   busy_o,
    output logic                   overflow_o,
    output logic                   timeout_o
);
    localparam int            CW           = $clog2(TIMEOUT_CYCLES + GAP_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);

    seq_state_t           state;
    logic [CW-1:0]        cnt;
    logic                 ack_seen;
    logic                 ack_now;
    logic                 empty;
    logic                 pop;
    logic [KEYCODE_W-1:0] head;

    assign pop     = (state == ST_IDLE) && !empty;
    assign ack_now = ack_seen || core_ack_in;
    assign busy_o  = (state != ST_IDLE) || !empty;

    key_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .clear_in     (clear_in),
        .push_in      (push_in),
        .push_data_in (push_keycode_in),
        .pop_in       (pop),
        .head_o       (head),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty)
    );

    // cnt counts completed cycles in the current PRESS or GAP, restarting at each entry
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            ack_seen      <= 1'b0;
            key_pending_o <= 1'b0;
            keycode_o     <= '0;
            overflow_o    <= 1'b0;
            timeout_o     <= 1'b0;
        end else if (clear_in) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            ack_seen      <= 1'b0;
            key_pending_o <= 1'b0;
            overflow_o    <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            if (push_in && full_o) begin
                overflow_o <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state         <= ST_PRESS;
                        keycode_o     <= head;
                        key_pending_o <= 1'b1;
                        cnt           <= '0;
                        ack_seen      <= 1'b0;
                    end
                end
                ST_PRESS: begin
                    if (cnt >= HOLD_LAST && ack_now) begin
                        state         <= ST_GAP;
                        key_pending_o <= 1'b0;
                        cnt           <= '0;
                        ack_seen      <= 1'b0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state         <= ST_GAP;
                        key_pending_o <= 1'b0;
                        cnt           <= '0;
                        ack_seen      <= 1'b0;
                        timeout_o     <= 1'b1;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        ack_seen <= ack_now;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_sequencer.sv
// tb/tb_key_sequencer.sv - Self-checking bench for key_sequencer
module tb_key_sequencer;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int GAP   = 3;
    localparam int TO    = 16;
    localparam int N     = 500;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       push_in = 1'b0;
    logic [7:0] push_keycode_in = 8'h00;
    logic       clear_in = 1'b0;
    logic       core_ack_in = 1'b0;
    logic       key_pending_o;
    logic [7:0] keycode_o;
    logic       full_o;
    logic [2:0] count_o;
    logic       busy_o;
    logic       overflow_o;
    logic       timeout_o;

    int tests = 0;
    int failed = 0;

    key_sequencer #(
        .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .push_in(push_in), .push_keycode_in(push_keycode_in),
        .clear_in(clear_in), .core_ack_in(core_ack_in), .key_pending_o(key_pending_o),
        .keycode_o(keycode_o), .full_o(full_o), .count_o(count_o), .busy_o(busy_o),
        .overflow_o(overflow_o), .timeout_o(timeout_o)
    );

    always #5 clk_in = ~clk_in;

    // {pending, keycode, count, full, busy, overflow, timeout}
    logic [15:0] obs;
    assign obs = {key_pending_o, keycode_o, count_o, full_o, busy_o, overflow_o, timeout_o};

    typedef struct {
        logic        push;
        logic [7:0]  key;
        logic        ack;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[10];

    logic        r_push [N + TO + 2];
    logic [7:0]  r_key  [N + TO + 2];
    logic        r_ack  [N + TO + 2];
    logic [15:0] r_exp  [N + 1];

    function automatic vec_t mk(input logic push, input logic [7:0] key, input logic ack,
                                input logic pend, input logic [7:0] kc, input logic [2:0] cnt,
                                input logic full, input logic busy, input logic ovf, input logic to);
        vec_t v;
        v.push = push;
        v.key  = key;
        v.ack  = ack;
        v.exp  = {pend, kc, cnt, full, busy, ovf, to};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        push_in = 1'b0;
        clear_in = 1'b0;
        core_ack_in = 1'b0;
        push_keycode_in = 8'h00;
        tick();
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic push_key(input logic [7:0] k);
        push_in = 1'b1;
        push_keycode_in = k;
        tick();
        push_in = 1'b0;
    endtask

    task automatic wait_pend(input logic val, input string name);
        int n;
        n = 0;
        while (key_pending_o !== val && n < 40) begin
            tick();
            n++;
        end
        check(name, 16'(key_pending_o), 16'(val));
    endtask

    // Called with key_pending_o just observed high; ack is held only during press cycle ack_idx
    task automatic press_len(input int ack_idx, output int len);
        len = 0;
        while (key_pending_o === 1'b1 && len < 64) begin
            core_ack_in = (len == ack_idx);
            tick();
            len++;
        end
        core_ack_in = 1'b0;
    endtask

    task automatic quiet(input int cycles, input string name);
        int highs;
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (key_pending_o !== 1'b0) highs++;
        end
        check(name, 16'(highs), 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ord [4];
        logic [7:0] q [$];
        int  len, idle_from, ps, pe, to_edge, first_ack, plen;
        logic do_pop, accept, m_ovf, m_pend, m_busy;
        logic [7:0] m_kc;

        // Reset state
        tick();
        check("reset_state", obs, 16'h0000);
        do_reset();

        // Single press with early ack, queue fill, overflow, next key
        tbl[0] = mk(1, 8'h90, 0, 0, 8'h00, 1, 0, 1, 0, 0);
        tbl[1] = mk(0, 8'h00, 0, 1, 8'h90, 0, 0, 1, 0, 0);
        tbl[2] = mk(1, 8'h41, 0, 1, 8'h90, 1, 0, 1, 0, 0);
        tbl[3] = mk(1, 8'h09, 1, 1, 8'h90, 2, 0, 1, 0, 0);
        tbl[4] = mk(1, 8'h4A, 0, 1, 8'h90, 3, 0, 1, 0, 0);
        tbl[5] = mk(1, 8'h39, 0, 0, 8'h90, 4, 1, 1, 0, 0);
        tbl[6] = mk(1, 8'h07, 0, 0, 8'h90, 4, 1, 1, 1, 0);
        tbl[7] = mk(0, 8'h00, 0, 0, 8'h90, 4, 1, 1, 1, 0);
        tbl[8] = mk(0, 8'h00, 0, 0, 8'h90, 4, 1, 1, 1, 0);
        tbl[9] = mk(0, 8'h00, 0, 1, 8'h41, 3, 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            push_in = tbl[i].push;
            push_keycode_in = tbl[i].key;
            core_ack_in = tbl[i].ack;
            tick();
            check($sformatf("table_edge%0d", i + 1), obs, tbl[i].exp);
        end
        push_in = 1'b0;
        core_ack_in = 1'b0;

        ord[0] = 8'h41; ord[1] = 8'h09; ord[2] = 8'h4A; ord[3] = 8'h39;
        for (int i = 0; i < 4; i++) begin
            wait_pend(1'b1, $sformatf("order_present%0d", i));
            check($sformatf("order_key%0d", i), 16'(keycode_o), 16'(ord[i]));
            press_len(0, len);
            check($sformatf("order_len%0d", i), 16'(len), 16'(HOLD));
        end
        quiet(14, "dropped_key_never_shown");
        check("drain_idle", 16'({busy_o, count_o, overflow_o}), 16'({1'b0, 3'd0, 1'b1}));
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        check("clear_overflow", 16'(overflow_o), 16'd0);

        // Never acked: timeout after TO cycles, next key still presented
        do_reset();
        push_key(8'h4A);
        push_in = 1'b1; push_keycode_in = 8'h55;
        tick();
        push_in = 1'b0;
        check("to_first_key", 16'({key_pending_o, keycode_o}), 16'({1'b1, 8'h4A}));
        press_len(-1, len);
        check("to_len", 16'(len), 16'(TO));
        check("to_flag", 16'(timeout_o), 16'd1);
        wait_pend(1'b1, "to_next_present");
        check("to_next_key", 16'(keycode_o), 16'h0055);
        press_len(0, len);
        check("to_next_len", 16'(len), 16'(HOLD));
        check("to_sticky", 16'(timeout_o), 16'd1);

        // Late ack stretches the press; busy drops after the gap
        do_reset();
        push_key(8'h07);
        tick();
        check("late_start", 16'({key_pending_o, keycode_o}), 16'({1'b1, 8'h07}));
        press_len(10, len);
        check("late_len", 16'(len), 16'd11);
        check("late_no_timeout", 16'(timeout_o), 16'd0);
        tick();
        tick();
        check("gap_busy", 16'({key_pending_o, busy_o}), 16'({1'b0, 1'b1}));
        tick();
        check("idle_not_busy", 16'({key_pending_o, busy_o}), 16'd0);

        // Asynchronous reset mid-press with three keys queued
        do_reset();
        push_key(8'h11);
        push_key(8'h22);
        push_key(8'h33);
        push_key(8'h44);
        check("pre_reset", 16'({key_pending_o, count_o}), 16'({1'b1, 3'd3}));
        #2;
        rst_in = 1'b1;
        #1;
        check("async_reset", 16'({key_pending_o, count_o, busy_o}), 16'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        quiet(15, "after_reset_quiet");

        // Clear during GAP with two keys queued
        do_reset();
        push_key(8'hA1);
        push_in = 1'b1; push_keycode_in = 8'hB2;
        tick();
        push_keycode_in = 8'hC3;
        tick();
        push_in = 1'b0;
        check("clr_press", 16'({key_pending_o, keycode_o, count_o}), 16'({1'b1, 8'hA1, 3'd2}));
        wait_pend(1'b0, "clr_press_end");
        check("clr_gap_state", 16'({timeout_o, count_o}), 16'({1'b1, 3'd2}));
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        check("clr_result", 16'({key_pending_o, count_o, full_o, busy_o, overflow_o, timeout_o}), 16'd0);
        quiet(15, "after_clear_quiet");

        // Randomized runs against an event-level model computed from whole-press timing
        for (int run = 0; run < 2; run++) begin
            for (int e = 0; e < N + TO + 2; e++) begin
                r_push[e] = (run == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 11) == 0);
                r_key[e]  = 8'($urandom);
                r_ack[e]  = ($urandom_range(0, 9) == 0);
            end
            q.delete();
            idle_from = 1; ps = 0; pe = 0; to_edge = 1 << 30;
            m_ovf = 1'b0; m_kc = 8'h00;
            for (int e = 1; e <= N; e++) begin
                do_pop = (e >= idle_from) && (q.size() > 0);
                accept = r_push[e] && (q.size() < DEPTH);
                if (r_push[e] && !accept) m_ovf = 1'b1;
                if (do_pop) begin
                    m_kc = q.pop_front();
                    first_ack = -1;
                    for (int k = 0; k < TO; k++) begin
                        if (first_ack < 0 && r_ack[e + k + 1]) first_ack = k;
                    end
                    if (first_ack < 0) plen = TO;
                    else plen = (first_ack + 1 > HOLD) ? first_ack + 1 : HOLD;
                    ps = e;
                    pe = e + plen;
                    idle_from = pe + GAP + 1;
                    if (first_ack < 0 && pe < to_edge) to_edge = pe;
                end
                if (accept) q.push_back(r_key[e]);
                m_pend = (e >= ps) && (e < pe);
                m_busy = (q.size() > 0) || (e >= ps && e < idle_from - 1);
                r_exp[e] = {m_pend, m_kc, 3'(q.size()), q.size() == DEPTH, m_busy, m_ovf, e >= to_edge};
            end
            do_reset();
            for (int e = 1; e <= N; e++) begin
                push_in = r_push[e];
                push_keycode_in = r_key[e];
                core_ack_in = r_ack[e];
                tick();
                check($sformatf("rand%0d_edge%0d", run, e), obs, r_exp[e]);
            end
            push_in = 1'b0;
            core_ack_in = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/key_sequencer.md
KEY_SEQUENCER -- requirements
Module: key_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: keycode FIFO entries (power of two, 2..16).
REQ-002 Parameter HOLD_CYCLES, default 4: minimum clk_in cycles key_pending_o stays high per key (>=1).
REQ-003 Parameter GAP_CYCLES, default 3: clk_in cycles key_pending_o stays low between keys (>=1).
REQ-004 Parameter TIMEOUT_CYCLES, default 16: maximum press length without acknowledge (>HOLD_CYCLES).
REQ-005 clk_in  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_in  input  1  asynchronous, active-high reset.
REQ-007 push_in  input  1  enqueue request, one key per cycle.
REQ-008 push_keycode_in  input  8  keycode to enqueue (e.g. 8'h90 = P/R).
REQ-009 clear_in  input  1  synchronous flush of FIFO, flags and press in progress.
REQ-010 core_ack_in  input  1  core has sampled the pending key (level, any cycle during press).
REQ-011 key_pending_o  output  1  key-down strobe to NClassic_core.
REQ-012 keycode_o  output  8  keycode presented to core; stable while key_pending_o high.
REQ-013 full_o  output  1  FIFO holds DEPTH entries.
REQ-014 count_o  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-015 busy_o  output  1  state is not IDLE or FIFO not empty.
REQ-016 overflow_o  output  1  sticky: a push was dropped.
REQ-017 timeout_o  output  1  sticky: a press ended without acknowledge.

Function
REQ-018 FSM states IDLE, PRESS, GAP; all outputs registered.
REQ-019 Push accepted only when full_o low at the start of that cycle; otherwise dropped and overflow_o set, even if a pop occurs in the same cycle.
REQ-020 Simultaneous accepted push and pop: count_o unchanged, order preserved (FIFO, oldest first).
REQ-021 IDLE with count_o>0: pop head, load keycode_o, set key_pending_o, enter PRESS on the same edge (push at edge N into empty FIFO -> key_pending_o high after edge N+1).
REQ-022 PRESS: core_ack_in latched into an internal ack_seen flag; hold and timeout counters run from PRESS entry.
REQ-023 PRESS -> GAP when HOLD_CYCLES cycles elapsed and (ack_seen or core_ack_in this cycle); key_pending_o therefore high for max(HOLD_CYCLES, ack cycle+1) cycles.
REQ-024 PRESS -> GAP after TIMEOUT_CYCLES cycles without acknowledge; timeout_o set.
REQ-025 GAP: key_pending_o low, keycode_o holds the last value, exits to IDLE after GAP_CYCLES cycles; core_ack_in ignored outside PRESS.
REQ-026 Pushes are accepted in every state; FIFO pointers wrap modulo DEPTH.
REQ-027 clear_in has priority over push and pop: FIFO emptied, flags cleared, key_pending_o low, state IDLE on the next edge.

Reset
REQ-028 rst_in asserted: immediately state IDLE, key_pending_o 0, keycode_o 8'h00, count_o 0, full_o 0, busy_o 0, overflow_o 0, timeout_o 0, counters 0, FIFO pointers 0.
REQ-029 Reset during PRESS aborts the key with no GAP; first operation after release follows REQ-021.

Structure
REQ-030 Shared package nclassic_pkg holds the FSM state encoding and the KEYCODE_W=8 constant.
REQ-031 One sub-module key_fifo (storage, pointers, count, full/empty); FSM and counters in key_sequencer.

Verification (HOLD=4, GAP=3, TIMEOUT=16, DEPTH=4)
REQ-032 Push 8'h90 in IDLE, ack on 2nd press cycle -> keycode_o=8'h90, key_pending_o high 4 cycles, then low 3 cycles, busy_o falls afterwards.
REQ-033 Push 8'h41,8'h09,8'h4A,8'h39 back-to-back, then 8'h07 -> full_o=1 after 4th accepted push, 8'h07 dropped, overflow_o=1; four keys presented in order, each acked.
REQ-034 Push 8'h4A, never ack -> key_pending_o high exactly 16 cycles, timeout_o=1, next queued key then presented normally.
REQ-035 Push 8'h07, ack on press cycle 10 -> key_pending_o high 11 cycles, timeout_o stays 0.
REQ-036 Assert rst_in mid-PRESS with 3 keys queued -> key_pending_o 0 without waiting for a clock edge, count_o=0, no key after release.
REQ-037 clear_in during GAP with 2 keys queued -> next cycle IDLE, count_o=0, overflow_o/timeout_o cleared, no further presses.
